// File: rtl/adpll_pkg.sv
// Shared types and helpers for the ADPLL loop filter.
//   gear_state_t : filter gear (ACQ = wide acquisition gains, TRK = fine tracking gains)
//   event_t      : signed phase-detector event (-1, 0, +1)
//   sat_add      : signed add clamped to [-lim, +lim]
package adpll_pkg;

    typedef enum logic {
        ACQ = 1'b0,
        TRK = 1'b1
    } gear_state_t;

    typedef logic signed [1:0] event_t;

    localparam event_t EV_ZERO = 2'sd0;
    localparam event_t EV_POS  = 2'sd1;
    localparam event_t EV_NEG  = -2'sd1;

    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input logic signed [31:0] lim
    );
        logic signed [31:0] s;
        s = a + b;
        if (s > lim) begin
            s = lim;
        end else if (s < -lim) begin
            s = -lim;
        end
        return s;
    endfunction

endpackage

// File: rtl/pi_filter_gearshift_if.sv
// Phase-detector / tuning-word bundle of the gear-shifting PI loop filter.
//   up, down, freeze : phase-detector events and hold request (master -> filter)
//   k_out            : signed DCO tuning word (filter -> master)
//   locked, sat      : tracking-gear flag and integrator-at-clamp flag
interface pi_filter_gearshift_if #(
    parameter int OUT_W = 13
);
    logic                    up;
    logic                    down;
    logic                    freeze;
    logic signed [OUT_W-1:0] k_out;
    logic                    locked;
    logic                    sat;

    modport master (output up, down, freeze, input k_out, locked, sat);
    modport slave  (input up, down, freeze, output k_out, locked, sat);
endinterface

// File: rtl/adpll_lock_detect.sv
// Lock detector: counts sign reversals and same-sign runs of the event stream
// and switches between acquisition and tracking gears.
//   clk, rst    : clock, synchronous active-high reset
//   ev          : current event (-1/0/+1)
//   locked      : current gear is TRK (combinational from state register)
//   gear_change : high on the edge where the gear switches
//   dir_change  : current event reverses the last nonzero sign
module adpll_lock_detect
    import adpll_pkg::*;
#(
    parameter int LOCK_REV   = 16,
    parameter int UNLOCK_RUN = 32
) (
    input  logic   clk,
    input  logic   rst,
    input  event_t ev,
    output logic   locked,
    output logic   gear_change,
    output logic   dir_change
);

    localparam int CNT_MAX = (LOCK_REV > UNLOCK_RUN) ? LOCK_REV : UNLOCK_RUN;
    localparam int CW      = $clog2(CNT_MAX + 1);

    gear_state_t   state_reg, state_next;
    logic [CW-1:0] rev_cnt_reg, rev_cnt_next, rev_inc;
    logic [CW-1:0] run_cnt_reg, run_cnt_next, run_inc;
    event_t        last_sign_reg, last_sign_next;
    logic          is_rev, is_same;

    // last_sign of zero means no event seen yet: the first event is neither
    // a reversal nor a continuation.
    assign is_rev     = (ev != EV_ZERO) && (last_sign_reg != EV_ZERO) && (ev != last_sign_reg);
    assign is_same    = (ev != EV_ZERO) && (ev == last_sign_reg);
    assign dir_change = is_rev;

    // Counters saturate so long stretches in the "wrong" gear cannot wrap.
    assign rev_inc = (rev_cnt_reg == CW'(CNT_MAX)) ? rev_cnt_reg : rev_cnt_reg + 1'b1;
    assign run_inc = (run_cnt_reg == CW'(CNT_MAX)) ? run_cnt_reg : run_cnt_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ACQ;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACQ: if (is_rev && (rev_inc == CW'(LOCK_REV)))    state_next = TRK;
            TRK: if (is_same && (run_inc == CW'(UNLOCK_RUN))) state_next = ACQ;
            default: state_next = ACQ;
        endcase
    end

    always_comb begin
        locked      = (state_reg == TRK);
        gear_change = (state_next != state_reg);
    end

    always_comb begin
        rev_cnt_next   = rev_cnt_reg;
        run_cnt_next   = run_cnt_reg;
        last_sign_next = last_sign_reg;
        if (ev != EV_ZERO) begin
            last_sign_next = ev;
        end
        if (gear_change) begin
            rev_cnt_next = '0;
            run_cnt_next = '0;
        end else if (is_rev) begin
            rev_cnt_next = rev_inc;
            run_cnt_next = CW'(1);
        end else if (is_same) begin
            rev_cnt_next = '0;
            run_cnt_next = run_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rev_cnt_reg   <= '0;
            run_cnt_reg   <= '0;
            last_sign_reg <= EV_ZERO;
        end else begin
            rev_cnt_reg   <= rev_cnt_next;
            run_cnt_reg   <= run_cnt_next;
            last_sign_reg <= last_sign_next;
        end
    end

endmodule

// File: rtl/pi_filter_gearshift.sv
// Gear-shifting PI loop filter: turns bang-bang phase-detector events into a
// signed DCO tuning word. Proportional pulses and integrator steps are
// prescaled by event counters; gains follow the lock detector's gear.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of pi_filter_gearshift_if (up/down/freeze in,
//              k_out/locked/sat out, all outputs registered)
module pi_filter_gearshift
    import adpll_pkg::*;
#(
    parameter int OUT_W      = 13,
    parameter int P_GAIN_ACQ = 8,
    parameter int I_GAIN_ACQ = 4,
    parameter int P_GAIN_TRK = 2,
    parameter int I_GAIN_TRK = 1,
    parameter int P_THRESH   = 5,
    parameter int I_THRESH   = 5,
    parameter int I_MAX      = 4000,
    parameter int LOCK_REV   = 16,
    parameter int UNLOCK_RUN = 32
) (
    input logic                 clk,
    input logic                 rst,
    pi_filter_gearshift_if.slave bus
);

    localparam int P_CNT_W = (P_THRESH > 0) ? $clog2(P_THRESH + 1) : 1;
    localparam int I_CNT_W = (I_THRESH > 0) ? $clog2(I_THRESH + 1) : 1;

    localparam logic signed [OUT_W-1:0] K_MAX   = OUT_W'((1 <<< (OUT_W - 1)) - 1);
    localparam logic signed [OUT_W:0]   K_MAX_W = (OUT_W + 1)'((1 <<< (OUT_W - 1)) - 1);
    localparam logic signed [OUT_W-1:0] I_MAX_V = OUT_W'(I_MAX);

    event_t ev;
    logic   locked_state, gear_change, dir_change;

    logic [P_CNT_W-1:0]      p_cnt_reg, p_cnt_next, p_base;
    logic [I_CNT_W-1:0]      i_cnt_reg, i_cnt_next, i_base;
    logic signed [OUT_W-1:0] p_pulse_reg, p_pulse_next;
    logic signed [OUT_W-1:0] i_term_reg, i_term_next;
    logic signed [31:0]      p_gain, i_gain;
    logic signed [OUT_W:0]   k_sum;
    logic signed [OUT_W-1:0] k_out_reg, k_next;
    logic                    sat_reg, sat_next, locked_reg;

    // Freeze and conflicting up/down both collapse to a null event.
    always_comb begin
        ev = EV_ZERO;
        if (!bus.freeze) begin
            if (bus.up && !bus.down) begin
                ev = EV_POS;
            end else if (bus.down && !bus.up) begin
                ev = EV_NEG;
            end
        end
    end

    adpll_lock_detect #(
        .LOCK_REV   (LOCK_REV),
        .UNLOCK_RUN (UNLOCK_RUN)
    ) u_lock (
        .clk         (clk),
        .rst         (rst),
        .ev          (ev),
        .locked      (locked_state),
        .gear_change (gear_change),
        .dir_change  (dir_change)
    );

    // Gains come from the gear in force before this edge, so the event that
    // triggers a gear change is still scaled by the old gains.
    always_comb begin
        p_gain       = locked_state ? P_GAIN_TRK : P_GAIN_ACQ;
        i_gain       = locked_state ? I_GAIN_TRK : I_GAIN_ACQ;
        p_base       = dir_change ? '0 : p_cnt_reg;
        i_base       = dir_change ? '0 : i_cnt_reg;
        p_cnt_next   = p_cnt_reg;
        i_cnt_next   = i_cnt_reg;
        p_pulse_next = '0;
        i_term_next  = i_term_reg;
        if (ev != EV_ZERO) begin
            if (p_base == P_CNT_W'(P_THRESH)) begin
                p_pulse_next = (ev == EV_POS) ? OUT_W'(p_gain) : OUT_W'(-p_gain);
                p_cnt_next   = '0;
            end else begin
                p_cnt_next = p_base + 1'b1;
            end
            if (i_base == I_CNT_W'(I_THRESH)) begin
                i_term_next = OUT_W'(sat_add(32'(i_term_reg),
                                             (ev == EV_POS) ? i_gain : -i_gain,
                                             I_MAX));
                i_cnt_next  = '0;
            end else begin
                i_cnt_next = i_base + 1'b1;
            end
            if (gear_change) begin
                p_cnt_next = '0;
                i_cnt_next = '0;
            end
        end
    end

    // One extra bit keeps the sum exact before clamping to the word range.
    always_comb begin
        k_sum = {i_term_reg[OUT_W-1], i_term_reg} + {p_pulse_reg[OUT_W-1], p_pulse_reg};
        if (k_sum > K_MAX_W) begin
            k_next = K_MAX;
        end else if (k_sum < -K_MAX_W) begin
            k_next = -K_MAX;
        end else begin
            k_next = k_sum[OUT_W-1:0];
        end
        sat_next = (i_term_reg == I_MAX_V) || (i_term_reg == -I_MAX_V);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_cnt_reg   <= '0;
            i_cnt_reg   <= '0;
            p_pulse_reg <= '0;
            i_term_reg  <= '0;
            k_out_reg   <= '0;
            sat_reg     <= 1'b0;
            locked_reg  <= 1'b0;
        end else begin
            p_cnt_reg   <= p_cnt_next;
            i_cnt_reg   <= i_cnt_next;
            p_pulse_reg <= p_pulse_next;
            i_term_reg  <= i_term_next;
            k_out_reg   <= k_next;
            sat_reg     <= sat_next;
            locked_reg  <= locked_state;
        end
    end

    assign bus.k_out  = k_out_reg;
    assign bus.sat    = sat_reg;
    assign bus.locked = locked_reg;

endmodule

// File: tb/tb_pi_filter_gearshift.sv
// Directed bench for pi_filter_gearshift: behavioural event-level model checked
// every cycle, plus hand-computed literal expectations per scenario.
module tb_pi_filter_gearshift;

    localparam int OUT_W      = 13;
    localparam int P_GAIN_ACQ = 8;
    localparam int I_GAIN_ACQ = 4;
    localparam int P_GAIN_TRK = 2;
    localparam int I_GAIN_TRK = 1;
    localparam int P_THRESH   = 5;
    localparam int I_THRESH   = 5;
    localparam int I_MAX      = 4000;
    localparam int LOCK_REV   = 16;
    localparam int UNLOCK_RUN = 32;
    localparam int K_LIM      = (1 << (OUT_W - 1)) - 1;

    logic clk;
    logic rst;
    pi_filter_gearshift_if #(.OUT_W(OUT_W)) bus ();

    pi_filter_gearshift #(
        .OUT_W(OUT_W), .P_GAIN_ACQ(P_GAIN_ACQ), .I_GAIN_ACQ(I_GAIN_ACQ),
        .P_GAIN_TRK(P_GAIN_TRK), .I_GAIN_TRK(I_GAIN_TRK),
        .P_THRESH(P_THRESH), .I_THRESH(I_THRESH), .I_MAX(I_MAX),
        .LOCK_REV(LOCK_REV), .UNLOCK_RUN(UNLOCK_RUN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model state: integrator value, pending pulse, event counts since last
    // pulse/step, last nonzero sign, reversal and run lengths, gear.
    int m_i, m_p, m_pc, m_ic, m_last, m_rev, m_run, m_trk;
    int exp_k, exp_sat, exp_locked;

    function automatic int clampi(input int x, input int lim);
        if (x > lim) return lim;
        if (x < -lim) return -lim;
        return x;
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp_v, $time);
        end
    endtask

    task automatic model_clear_counts();
        m_pc = 0; m_ic = 0; m_rev = 0; m_run = 0;
    endtask

    // Called once per clock edge with the inputs sampled at that edge.
    task automatic model_step(input bit u, input bit d, input bit f, input bit r);
        int e, pg, ig;
        bit rev, same;
        if (r) begin
            m_i = 0; m_p = 0; m_last = 0; m_trk = 0;
            model_clear_counts();
            exp_k = 0; exp_sat = 0; exp_locked = 0;
        end else begin
            // Outputs after this edge show the filter as it stood before it.
            exp_k      = clampi(m_i + m_p, K_LIM);
            exp_sat    = ((m_i == I_MAX) || (m_i == -I_MAX)) ? 1 : 0;
            exp_locked = m_trk;
            e = 0;
            if (!f && u && !d) e = 1;
            if (!f && d && !u) e = -1;
            m_p = 0;
            if (e != 0) begin
                pg   = (m_trk != 0) ? P_GAIN_TRK : P_GAIN_ACQ;
                ig   = (m_trk != 0) ? I_GAIN_TRK : I_GAIN_ACQ;
                rev  = (m_last != 0) && (e != m_last);
                same = (e == m_last);
                if (rev) begin
                    m_pc = 0; m_ic = 0;
                end
                if (m_pc == P_THRESH) begin m_p = e * pg; m_pc = 0; end
                else m_pc++;
                if (m_ic == I_THRESH) begin m_i = clampi(m_i + e * ig, I_MAX); m_ic = 0; end
                else m_ic++;
                if (rev) begin m_rev++; m_run = 1; end
                else if (same) begin m_rev = 0; m_run++; end
                m_last = e;
                if (m_trk == 0 && m_rev >= LOCK_REV) begin
                    m_trk = 1; model_clear_counts();
                end else if (m_trk != 0 && m_run >= UNLOCK_RUN) begin
                    m_trk = 0; model_clear_counts();
                end
            end
        end
    endtask

    // Drive inputs, take one edge, advance the model, return at the negedge.
    task automatic tick(input bit u, input bit d, input bit f, input bit r);
        bus.up = u; bus.down = d; bus.freeze = f; rst = r;
        @(posedge clk);
        model_step(u, d, f, r);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_k_out", int'(bus.k_out), exp_k);
            chk("model_sat", int'(bus.sat), exp_sat);
            chk("model_locked", int'(bus.locked), exp_locked);
        end
    end

    function automatic int kv();
        return int'(bus.k_out);
    endfunction

    task automatic phase(input string name);
        $display("phase %s k_out=%0d locked=%0d sat=%0d", name, kv(), bus.locked, bus.sat);
    endtask

    int kmax, hits;

    initial begin
        bus.up = 0; bus.down = 0; bus.freeze = 0; rst = 1;
        m_i = 0; m_p = 0; m_last = 0; m_trk = 0;
        model_clear_counts();
        exp_k = 0; exp_sat = 0; exp_locked = 0;

        // Reset held with up asserted.
        repeat (3) tick(1, 0, 0, 1);
        chk_en = 1'b1;
        chk("rst_k_out", kv(), 0);
        chk("rst_locked", int'(bus.locked), 0);
        chk("rst_sat", int'(bus.sat), 0);
        phase("reset");

        // Six ups in ACQ: pulse +8 and step +4 on the sixth.
        tick(1, 0, 0, 0);
        chk("first_edge_k_out", kv(), 0);
        repeat (5) tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("acq_pulse_k_out", kv(), 12);
        tick(0, 0, 0, 0);
        chk("acq_after_pulse_k_out", kv(), 4);
        phase("acq_six_ups");

        // Direction change: 4 ups, then 6 downs -> -8 pulse, -4 step.
        repeat (2) tick(0, 0, 0, 1);
        repeat (4) tick(1, 0, 0, 0);
        chk("dir_ups_k_out", kv(), 0);
        repeat (6) tick(0, 1, 0, 0);
        tick(0, 0, 0, 0);
        chk("dir_pulse_k_out", kv(), -12);
        tick(0, 0, 0, 0);
        chk("dir_after_k_out", kv(), -4);
        repeat (3) tick(1, 0, 0, 0);
        tick(1, 0, 0, 1);
        chk("mid_rst_k_out", kv(), 0);
        phase("direction_change");

        // Lock after 17 alternating events, tracking gains, unlock after 32-run.
        tick(0, 0, 0, 1);
        for (int n = 0; n < 17; n++) tick(n % 2 == 0, n % 2 == 1, 0, 0);
        chk("lock_not_yet", int'(bus.locked), 0);
        tick(0, 0, 0, 0);
        chk("lock_locked", int'(bus.locked), 1);
        repeat (6) tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("trk_pulse_k_out", kv(), 3);
        tick(0, 0, 0, 0);
        chk("trk_after_k_out", kv(), 1);
        repeat (26) tick(1, 0, 0, 0);
        chk("unlock_not_yet", int'(bus.locked), 1);
        tick(0, 0, 0, 0);
        chk("unlock_locked", int'(bus.locked), 0);
        chk("unlock_k_out", kv(), 5);
        repeat (6) tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("reacq_pulse_k_out", kv(), 17);
        phase("lock_unlock");

        // Conflicting inputs and freeze leave everything untouched.
        repeat (100) tick(1, 1, 0, 0);
        repeat (100) tick(1, 0, 1, 0);
        chk("hold_k_out", kv(), 9);
        chk("hold_locked", int'(bus.locked), 0);
        repeat (6) tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("hold_resume_k_out", kv(), 21);
        phase("hold_freeze");

        // Saturation: integrator clamps at 4000, output peaks at 4008.
        tick(0, 0, 0, 1);
        kmax = -100000;
        hits = 0;
        repeat (6100) begin
            tick(1, 0, 0, 0);
            if (kv() > kmax) kmax = kv();
            if (kv() == 4008) hits++;
        end
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("sat_k_max", kmax, 4008);
        chk("sat_peak_count", hits, 17);
        chk("sat_flag", int'(bus.sat), 1);
        chk("sat_k_idle", kv(), 4000);
        phase("saturation");

        tick(1, 0, 0, 1);
        chk("final_rst_k_out", kv(), 0);
        chk("final_rst_sat", int'(bus.sat), 0);
        phase("final_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
